// File: rtl/dsky_relay_decoder.sv
// -----------------------------------------------------------------------------
// dsky_relay_decoder
//
// Consumes the AGC relay-word outputs (RYWD16/14/13/12 row select and
// RLYB11..RLYB01 data), rejects short-lived glitches by requiring the same
// nonzero word for STABLE_CYCLES consecutive samples, and commits each stable
// word into a 12-row DSKY image. A registered read port returns a row's raw
// contents together with its two decoded relay digits.
//
// Ports:
//   SIM_CLK              system clock (51.2 MHz)
//   SIM_RST              synchronous, active-high reset
//   RYWD16..RYWD12       row address bits 3..0
//   RLYB11..RLYB01       relay data bits 10..0
//   rd_addr[3:0]         read row select (1..12 valid)
//   rd_word[10:0]        stored row data, one cycle after rd_addr
//   rd_dig_hi[3:0]       decoded digit from data[9:5] (15 blank, 14 invalid)
//   rd_dig_lo[3:0]       decoded digit from data[4:0] (15 blank, 14 invalid)
//   upd                  one-cycle pulse on each committed row write
//   upd_addr[3:0]        row written; holds its last value when upd is low
//   commit_cnt[15:0]     number of row writes, wraps
//   bad_cnt[7:0]         number of stable words addressing rows 13..15,
//                        saturates at 255
//
// STABLE_CYCLES: consecutive identical samples needed to commit (2..255).
// -----------------------------------------------------------------------------
module dsky_relay_decoder #(
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        RYWD16,
    input  logic        RYWD14,
    input  logic        RYWD13,
    input  logic        RYWD12,
    input  logic        RLYB11,
    input  logic        RLYB10,
    input  logic        RLYB09,
    input  logic        RLYB08,
    input  logic        RLYB07,
    input  logic        RLYB06,
    input  logic        RLYB05,
    input  logic        RLYB04,
    input  logic        RLYB03,
    input  logic        RLYB02,
    input  logic        RLYB01,
    input  logic [3:0]  rd_addr,
    output logic [10:0] rd_word,
    output logic [3:0]  rd_dig_hi,
    output logic [3:0]  rd_dig_lo,
    output logic        upd,
    output logic [3:0]  upd_addr,
    output logic [15:0] commit_cnt,
    output logic [7:0]  bad_cnt
);

    // The sample that completes a run of STABLE_CYCLES is the one taken
    // while cnt already holds STABLE_CYCLES-1.
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // Current relay word {row[3:0], data[10:0]}; it is captured by the
    // candidate/counter registers on every edge, so each edge sees one sample.
    logic [14:0] s_word;

    state_t      state, state_n;
    logic [14:0] cand, cand_n;
    logic [7:0]  cnt, cnt_n;
    logic        commit;

    logic [3:0]  cand_row;
    logic        write_row;
    logic        bad_row;

    logic [10:0] rows [1:12];
    logic [10:0] rd_raw;

    assign s_word = {RYWD16, RYWD14, RYWD13, RYWD12,
                     RLYB11, RLYB10, RLYB09, RLYB08, RLYB07, RLYB06,
                     RLYB05, RLYB04, RLYB03, RLYB02, RLYB01};

    // Relay 5-bit segment code to digit; all-zero is a blank position.
    function automatic logic [3:0] decode_digit(input logic [4:0] code);
        case (code)
            5'b00000: decode_digit = 4'd15;
            5'b10101: decode_digit = 4'd0;
            5'b00011: decode_digit = 4'd1;
            5'b11001: decode_digit = 4'd2;
            5'b11011: decode_digit = 4'd3;
            5'b01111: decode_digit = 4'd4;
            5'b11110: decode_digit = 4'd5;
            5'b11100: decode_digit = 4'd6;
            5'b10011: decode_digit = 4'd7;
            5'b11101: decode_digit = 4'd8;
            5'b11111: decode_digit = 4'd9;
            default:  decode_digit = 4'd14;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Glitch-filter FSM: next state and commit strobe
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        commit  = 1'b0;

        case (state)
            IDLE: begin
                if (s_word != '0) begin
                    state_n = SETTLE;
                    cand_n  = s_word;
                    cnt_n   = 8'd1;
                end
            end

            SETTLE: begin
                if (s_word == '0) begin
                    state_n = IDLE;
                end else if (s_word == cand) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == LAST_CNT) begin
                        commit  = 1'b1;
                        state_n = HOLD;
                    end
                end else begin
                    cand_n = s_word;
                    cnt_n  = 8'd1;
                end
            end

            HOLD: begin
                // A word held indefinitely is committed only once.
                if (s_word == '0) begin
                    state_n = IDLE;
                end else if (s_word != cand) begin
                    state_n = SETTLE;
                    cand_n  = s_word;
                    cnt_n   = 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge SIM_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and updates together.
        if (SIM_RST) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // Commit classification: rows 1..12 are written, 0 is silently accepted,
    // 13..15 are counted as bad.
    // -------------------------------------------------------------------------
    assign cand_row  = cand[14:11];
    assign write_row = commit && (cand_row >= 4'd1) && (cand_row <= 4'd12);
    assign bad_row   = commit && (cand_row >= 4'd13);

    // Unmapped read addresses yield zero data, which decodes to blank digits.
    always_comb begin
        rd_raw = '0;
        if ((rd_addr >= 4'd1) && (rd_addr <= 4'd12)) begin
            rd_raw = rows[rd_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Row image, read port and status counters
    // -------------------------------------------------------------------------
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            // NOTE: the row image is reset explicitly because never-written
            // rows must read back as zero; a reset-less RAM cannot promise it.
            for (int i = 1; i <= 12; i++) begin
                rows[i] <= '0;
            end
            rd_word    <= '0;
            rd_dig_hi  <= 4'd15;
            rd_dig_lo  <= 4'd15;
            upd        <= 1'b0;
            upd_addr   <= '0;
            commit_cnt <= '0;
            bad_cnt    <= '0;
        end else begin
            // Read uses the pre-edge row contents, so a same-edge commit to
            // the selected row shows up one cycle later (read-before-write).
            rd_word   <= rd_raw;
            rd_dig_hi <= decode_digit(rd_raw[9:5]);
            rd_dig_lo <= decode_digit(rd_raw[4:0]);

            upd <= write_row;
            if (write_row) begin
                rows[cand_row] <= cand[10:0];
                upd_addr       <= cand_row;
                commit_cnt     <= commit_cnt + 16'd1;
            end

            if (bad_row && (bad_cnt != 8'hFF)) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dsky_relay_decoder.sv
// -----------------------------------------------------------------------------
// tb_dsky_relay_decoder
//
// Self-checking bench for dsky_relay_decoder. Every expected commit is pushed
// to a scoreboard queue when the stimulus is driven; tick() pops and compares
// whenever the DUT pulses upd. A shadow row image and expected counters give
// the read-port and status expectations.
// -----------------------------------------------------------------------------
module tb_dsky_relay_decoder;

    localparam int S = 8;

    typedef struct packed {
        logic [3:0]  addr;
        logic [10:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [10:0] data_in;
    logic [3:0]  rd_addr;
    logic [10:0] rd_word;
    logic [3:0]  rd_dig_hi;
    logic [3:0]  rd_dig_lo;
    logic        upd;
    logic [3:0]  upd_addr;
    logic [15:0] commit_cnt;
    logic [7:0]  bad_cnt;

    exp_t        sb[$];
    logic [10:0] model_rows [0:15];
    logic [4:0]  dig_code [0:9] = '{5'b10101, 5'b00011, 5'b11001, 5'b11011,
                                    5'b01111, 5'b11110, 5'b11100, 5'b10011,
                                    5'b11101, 5'b11111};
    int errors     = 0;
    int checks     = 0;
    int upd_pulses = 0;
    int exp_commit = 0;
    int exp_bad    = 0;

    always #5 clk = ~clk;

    dsky_relay_decoder #(.STABLE_CYCLES(S)) dut (
        .SIM_CLK    (clk),
        .SIM_RST    (rst),
        .RYWD16     (row_in[3]),
        .RYWD14     (row_in[2]),
        .RYWD13     (row_in[1]),
        .RYWD12     (row_in[0]),
        .RLYB11     (data_in[10]),
        .RLYB10     (data_in[9]),
        .RLYB09     (data_in[8]),
        .RLYB08     (data_in[7]),
        .RLYB07     (data_in[6]),
        .RLYB06     (data_in[5]),
        .RLYB05     (data_in[4]),
        .RLYB04     (data_in[3]),
        .RLYB03     (data_in[2]),
        .RLYB02     (data_in[1]),
        .RLYB01     (data_in[0]),
        .rd_addr    (rd_addr),
        .rd_word    (rd_word),
        .rd_dig_hi  (rd_dig_hi),
        .rd_dig_lo  (rd_dig_lo),
        .upd        (upd),
        .upd_addr   (upd_addr),
        .commit_cnt (commit_cnt),
        .bad_cnt    (bad_cnt)
    );

    // Digit expected from a relay code, from the code table.
    function automatic logic [3:0] exp_digit(input logic [4:0] c);
        exp_digit = 4'd14;
        if (c == 5'b00000) exp_digit = 4'd15;
        for (int i = 0; i < 10; i++) begin
            if (c == dig_code[i]) exp_digit = 4'(i);
        end
    endfunction

    // Advance one cycle; sample at the falling edge and score any upd pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (upd === 1'b1) begin
            upd_pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_upd: upd_addr=%0d but no commit expected", upd_addr);
            end else begin
                e = sb.pop_front();
                if (upd_addr !== e.addr) begin
                    errors++;
                    $display("FAIL upd_addr: got %0d expected %0d", upd_addr, e.addr);
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [10:0] d);
        row_in  = r;
        data_in = d;
    endtask

    task automatic present(input logic [3:0] r, input logic [10:0] d, input int n);
        drive(r, d);
        repeat (n) tick();
    endtask

    // Record the effect a stable word will have once it commits.
    task automatic expect_commit(input logic [3:0] r, input logic [10:0] d);
        if (r >= 4'd1 && r <= 4'd12) begin
            sb.push_back('{addr: r, data: d});
            model_rows[r] = d;
            exp_commit    = (exp_commit + 1) % 65536;
        end else if (r >= 4'd13) begin
            if (exp_bad < 255) exp_bad++;
        end
    endtask

    task automatic commit_word(input logic [3:0] r, input logic [10:0] d);
        expect_commit(r, d);
        present(r, d, S);
        present(4'd0, 11'd0, 1);
    endtask

    task automatic check_read(input logic [3:0] a);
        logic [10:0] w;
        w = (a >= 4'd1 && a <= 4'd12) ? model_rows[a] : 11'd0;
        rd_addr = a;
        tick();
        checks++;
        if (rd_word !== w || rd_dig_hi !== exp_digit(w[9:5]) || rd_dig_lo !== exp_digit(w[4:0])) begin
            errors++;
            $display("FAIL read_row%0d: got %h/%0d/%0d expected %h/%0d/%0d", a, rd_word,
                     rd_dig_hi, rd_dig_lo, w, exp_digit(w[9:5]), exp_digit(w[4:0]));
        end
    endtask

    task automatic check_counters(input string tag);
        checks++;
        if (commit_cnt !== 16'(exp_commit) || bad_cnt !== 8'(exp_bad)) begin
            errors++;
            $display("FAIL %s_counters: commit_cnt=%0d bad_cnt=%0d expected %0d/%0d", tag,
                     commit_cnt, bad_cnt, exp_commit, exp_bad);
        end
    endtask

    task automatic check_sb_empty(input string tag, input int pulses_before, input int want);
        checks++;
        if (sb.size() != 0 || (upd_pulses - pulses_before) != want) begin
            errors++;
            $display("FAIL %s_pulses: got %0d pulses, %0d pending, expected %0d pulses", tag,
                     upd_pulses - pulses_before, sb.size(), want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (rd_word !== 11'd0 || rd_dig_hi !== 4'd15 || rd_dig_lo !== 4'd15 || upd !== 1'b0 ||
            upd_addr !== 4'd0 || commit_cnt !== 16'd0 || bad_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s: rd=%h hi=%0d lo=%0d upd=%b addr=%0d cc=%0d bc=%0d expected all reset values",
                     tag, rd_word, rd_dig_hi, rd_dig_lo, upd, upd_addr, commit_cnt, bad_cnt);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model_rows[i] = 11'd0;
        sb.delete();
        exp_commit = 0;
        exp_bad    = 0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        rd_addr = 4'd0;
        drive(4'd0, 11'd0);
        clear_model();
        repeat (2) tick();
        check_reset_outputs("reset_values");
        rst = 1'b0;
        for (int a = 0; a < 16; a++) check_read(4'(a));
    endtask

    task automatic test_basic();
        logic early;
        int   p0;
        p0      = upd_pulses;
        early   = 1'b0;
        rd_addr = 4'd11;
        tick();
        expect_commit(4'd11, 11'h2A3);
        drive(4'd11, 11'h2A3);
        for (int i = 0; i < S - 1; i++) begin
            tick();
            if (upd === 1'b1) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_upd: upd seen before sample %0d", S);
        end
        tick();
        checks++;
        if (upd !== 1'b1 || upd_addr !== 4'd11 || rd_word !== 11'd0) begin
            errors++;
            $display("FAIL basic_commit_edge: upd=%b addr=%0d rd=%h expected 1/11/000", upd, upd_addr, rd_word);
        end
        tick();
        checks++;
        if (upd !== 1'b0 || rd_word !== 11'h2A3 || rd_dig_hi !== 4'd0 || rd_dig_lo !== 4'd1) begin
            errors++;
            $display("FAIL basic_readback: upd=%b rd=%h hi=%0d lo=%0d expected 0/2a3/0/1", upd, rd_word,
                     rd_dig_hi, rd_dig_lo);
        end
        check_counters("basic");
        // Holding the same word must not commit again.
        repeat (20) tick();
        present(4'd0, 11'd0, 1);
        check_sb_empty("basic_hold", p0, 1);
    endtask

    task automatic test_glitch();
        logic [10:0] d0;
        int          p0;
        p0 = upd_pulses;
        d0 = {1'b0, 5'b11001, 5'b11011};
        for (int i = 0; i < 40; i++) present(4'd3, d0 ^ 11'((i / 5) % 2), 1);
        check_sb_empty("glitch_toggle", p0, 0);
        expect_commit(4'd3, d0);
        present(4'd3, d0, S);
        present(4'd0, 11'd0, 2);
        // One sample short of the threshold must never commit.
        present(4'd4, 11'h155, S - 1);
        present(4'd0, 11'd0, 3);
        check_sb_empty("glitch", p0, 1);
        check_read(4'd3);
        check_read(4'd4);
        check_counters("glitch");
    endtask

    task automatic test_back_to_back();
        logic [10:0] w;
        int          p0;
        p0 = upd_pulses;
        w  = {1'b1, 5'b11110, 5'b11100};
        expect_commit(4'd7, w);
        present(4'd7, w, 100);
        present(4'd0, 11'd0, 1);
        expect_commit(4'd7, w);
        present(4'd7, w, S);
        present(4'd0, 11'd0, 2);
        check_sb_empty("repeat", p0, 2);
        check_counters("repeat");
        check_read(4'd7);
    endtask

    task automatic test_decode();
        for (int k = 0; k < 5; k++) begin
            commit_word(4'(k + 1), {1'(k), dig_code[2 * k], dig_code[2 * k + 1]});
        end
        commit_word(4'd12, {1'b1, 5'b00000, 5'b10000});
        for (int a = 1; a <= 5; a++) check_read(4'(a));
        check_read(4'd12);
        check_counters("decode");
    endtask

    task automatic test_read_collision();
        logic [10:0] v1, v2;
        v1 = {1'b0, 5'b11001, 5'b11011};
        v2 = {1'b1, 5'b01000, 5'b00000};
        commit_word(4'd5, v1);
        rd_addr = 4'd5;
        tick();
        expect_commit(4'd5, v2);
        drive(4'd5, v2);
        repeat (S - 1) tick();
        tick();
        checks++;
        if (upd !== 1'b1 || rd_word !== v1 || rd_dig_hi !== 4'd2 || rd_dig_lo !== 4'd3) begin
            errors++;
            $display("FAIL collision_old: upd=%b rd=%h hi=%0d lo=%0d expected 1/%h/2/3", upd, rd_word,
                     rd_dig_hi, rd_dig_lo, v1);
        end
        tick();
        checks++;
        if (rd_word !== v2 || rd_dig_hi !== 4'd14 || rd_dig_lo !== 4'd15) begin
            errors++;
            $display("FAIL collision_new: rd=%h hi=%0d lo=%0d expected %h/14/15", rd_word, rd_dig_hi,
                     rd_dig_lo, v2);
        end
        present(4'd0, 11'd0, 1);
        check_read(4'd13);
        check_read(4'd0);
        check_read(4'd15);
    endtask

    task automatic test_bad_rows();
        int p0;
        p0 = upd_pulses;
        // Row 0 with nonzero data is accepted but changes nothing visible.
        present(4'd0, 11'h0A5, S);
        present(4'd0, 11'd0, 1);
        check_counters("row0");
        for (int i = 0; i < 300; i++) begin
            commit_word(4'd14, 11'(i));
            if (i == 253) check_counters("bad_254");
        end
        check_counters("bad_sat");
        check_sb_empty("bad", p0, 0);
        for (int a = 0; a < 16; a++) check_read(4'(a));
    endtask

    task automatic test_reset_mid_settle();
        int p0;
        p0      = upd_pulses;
        rd_addr = 4'd2;
        drive(4'd2, 11'h3FF);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        clear_model();
        check_reset_outputs("reset_mid");
        rst = 1'b0;
        // Remaining samples after reset are too few to commit on their own.
        repeat (3) tick();
        present(4'd0, 11'd0, 4);
        check_sb_empty("reset_mid", p0, 0);
        check_read(4'd2);
        check_read(4'd11);
        check_counters("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_back_to_back();
        test_decode();
        test_read_collision();
        test_bad_rows();
        test_reset_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
